// File: rtl/quotient_register.sv
// quotient_register: iterative quotient/root accumulator for the MDR datapath.
// Each RUN cycle shifts ~rem_sign into quo. After N iterations it pulses done
// and returns to IDLE. N is DW for DIV, MULT and undefined encodings, and DW/2
// for ROOT. quo_x2 feeds the w_quo_X_a2 input of the quotient output mux.
// Optional feature: define QUO_ABORT_EN to add an 'abort' input, which cancels
// a running operation and clears the result.

package pkg_system_mdr;
  typedef enum logic [1:0] {
    MULT = 2'd0,
    DIV  = 2'd1,
    ROOT = 2'd2
  } mdr_op_e;
endpackage

module quotient_register
  import pkg_system_mdr::*;
#(
  parameter int DW = 16,
  parameter int CW = $clog2(DW) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic          rem_sign,
`ifdef QUO_ABORT_EN
  input  logic          abort,
`endif
  output logic [DW-1:0] quo,
  output logic [DW-1:0] quo_x2,
  output logic [CW-1:0] count,
  output logic          busy,
  output logic          done,
  output logic          state_dbg
);

  // Handshake: start is a level that is sampled only on an IDLE edge. busy is
  // high from the accepting edge until the completing edge. done is a single
  // cycle pulse after the completing edge. Because that done cycle is already
  // IDLE, a start held in that cycle is accepted back-to-back.

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e        state;
  logic [1:0]    op_q;
  logic [CW-1:0] last_cnt;
  logic [DW-1:0] quo_next;

  // Count value on the edge before the completing edge.
  // ROOT needs DW/2 iterations. Every other encoding needs DW.
  always_comb begin
    last_cnt = CW'(DW - 1);
    if (op_q == 2'(ROOT)) last_cnt = CW'(DW / 2 - 1);
  end

  // Next quotient: MULT only tracks timing, so it keeps quo at zero.
  always_comb begin
    quo_next = {quo[DW-2:0], ~rem_sign};
    if (op_q == 2'(MULT)) quo_next = '0;
  end

  // Main FSM: accepts start, shifts quotient bits and completes after N steps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      op_q  <= 2'(DIV);
      quo   <= '0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q  <= op;
            quo   <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
`ifdef QUO_ABORT_EN
          if (abort) begin
            quo   <= '0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            state <= IDLE;
          end else
`endif
          begin
            quo   <= quo_next;
            count <= count + 1'b1;
            if (count == last_cnt) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign quo_x2    = {quo[DW-2:0], 1'b0};
  assign state_dbg = (state == RUN);

endmodule

// File: tb/tb_quotient_register.sv
// Testbench for quotient_register at DW=8.
// The reference model builds each operation's final result arithmetically from
// its rem_sign sequence. The partial result after i steps is that value shifted
// right by N-i.
module tb_quotient_register;
  import pkg_system_mdr::*;

  localparam int DW = 8;
  localparam int CW = $clog2(DW) + 1;

  logic          clk;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic          rem_sign;
  logic          abort;
  logic [DW-1:0] quo;
  logic [DW-1:0] quo_x2;
  logic [CW-1:0] count;
  logic          busy;
  logic          done;
  logic          state_dbg;

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] held_quo;

  quotient_register #(.DW(DW), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .rem_sign  (rem_sign),
`ifdef QUO_ABORT_EN
    .abort     (abort),
`endif
    .quo       (quo),
    .quo_x2    (quo_x2),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  // Checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", tag, got, exp);
    end
  endtask

  // Reference model: the final result of an operation from its rem_sign bits.
  // bits[j] is the rem_sign value applied on iteration j+1.
  function automatic logic [DW-1:0] final_quo(input logic [1:0] o, input logic [15:0] bits,
                                              input int n);
    int v;
    v = 0;
    if (o == 2'(MULT)) return '0;
    for (int j = 0; j < n; j++) v = (v * 2 + (bits[j] ? 0 : 1)) % (1 << DW);
    return DW'(v);
  endfunction

  function automatic int iter_limit(input logic [1:0] o);
    return (o == 2'(ROOT)) ? DW / 2 : DW;
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic [DW-1:0] q, input logic [31:0] cnt);
    check({tag, "_quo"}, quo, q);
    check({tag, "_cnt"}, count, cnt);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_state"}, state_dbg, 0);
  endtask

  // Runs one operation. glitch_at re-asserts start with a different op on that
  // iteration. abort_at (0 = never) raises abort on that iteration.
  task automatic run_op(input logic [1:0] o, input logic [15:0] bits, input int glitch_at,
                        input int abort_at);
    int n;
    logic [DW-1:0] fin;
    logic [DW-1:0] e_quo;
    logic [DW-1:0] e_x2;
    logic [DW-1:0] sb;
    n   = iter_limit(o);
    fin = final_quo(o, bits, n);
    exp_q.push_back(fin);
    start = 1'b1;
    op    = o;
    tick();
    start = 1'b0;
    op    = 2'($urandom_range(0, 3));
    check("acc_busy", busy, 1);
    check("acc_quo", quo, 0);
    check("acc_cnt", count, 0);
    check("acc_done", done, 0);
    for (int i = 1; i <= n; i++) begin
      rem_sign = bits[i-1];
      if (i == glitch_at) begin
        start = 1'b1;
        op    = (o == 2'(ROOT)) ? 2'(DIV) : 2'(ROOT);
      end
      abort = (i == abort_at);
      tick();
      start = 1'b0;
      abort = 1'b0;
`ifdef QUO_ABORT_EN
      if (i == abort_at) begin
        check_idle("abort", 0, 0);
        void'(exp_q.pop_back());
        held_quo = '0;
        tick();
        check("abort_nodone", done, 0);
        return;
      end
`endif
      e_quo = (o == 2'(MULT)) ? '0 : DW'(fin >> (n - i));
      e_x2  = DW'(e_quo << 1);
      check("run_quo", quo, e_quo);
      check("run_x2", quo_x2, e_x2);
      check("run_cnt", count, i);
      check("run_busy", busy, (i < n) ? 1 : 0);
      check("run_done", done, (i == n) ? 1 : 0);
      if (i == n && done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("sb_empty", 1, 0);
        end else begin
          sb = exp_q.pop_front();
          check("sb_result", quo, sb);
        end
      end
    end
    held_quo = fin;
  endtask

  // Stimulus
  initial begin
    logic [1:0]  ro;
    logic [15:0] rb;
    int          gap;
    rst      = 1'b0;
    start    = 1'b0;
    op       = 2'(DIV);
    rem_sign = 1'b0;
    abort    = 1'b0;
    held_quo = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset", 0, 0);
    check("reset_x2", quo_x2, 0);
    #3 rst = 1'b1;
    tick();

    // DIV with rem_sign 0,1,0,0,1,1,0,1 gives 8'hB2
    run_op(2'(DIV), 16'h00B2, 0, 0);
    check("div_const", quo, 8'hB2);
    check("div_x2_const", quo_x2, 8'h64);
    check("div_cnt_const", count, 8);
    tick();
    check("div_done_fall", done, 0);

    // ROOT with rem_sign 0,1,1,0 gives 8'h09, which must then be held
    run_op(2'(ROOT), 16'h0006, 0, 0);
    check("root_const", quo, 8'h09);
    check("root_x2_const", quo_x2, 8'h12);
    for (int k = 0; k < 10; k++) begin
      tick();
      check_idle("root_hold", 8'h09, 4);
    end

    // MULT: quo stays zero
    run_op(2'(MULT), 16'($urandom()), 0, 0);
    tick();
    check_idle("mult_idle", 0, 8);

    // Restart during RUN is ignored. Then start in the done cycle is accepted.
    run_op(2'(DIV), 16'($urandom()), 3, 0);
    run_op(2'(DIV), 16'($urandom()), 0, 0);
    tick();

    // Asynchronous reset in the middle of a cycle after edge 5
    start = 1'b1;
    op    = 2'(DIV);
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rem_sign = 1'b0;
      tick();
    end
    check("pre_rst_cnt", count, 5);
    #3 rst = 1'b0;
    #1;
    check_idle("async_rst", 0, 0);
    #2 rst = 1'b1;
    tick();
    run_op(2'(DIV), 16'($urandom()), 0, 0);
    tick();

`ifdef QUO_ABORT_EN
    run_op(2'(DIV), 16'($urandom()), 0, 4);
    run_op(2'(DIV), 16'($urandom()), 0, 8);
    // abort is ignored in IDLE, and start wins when both are raised
    abort = 1'b1;
    tick();
    check_idle("idle_abort", 0, 0);
    abort = 1'b0;
    run_op(2'(ROOT), 16'($urandom()), 0, 0);
    tick();
`endif

    // Random operations, including the undefined encoding, with random gaps
    for (int t = 0; t < 24; t++) begin
      ro = 2'($urandom_range(0, 3));
      rb = 16'($urandom());
      run_op(ro, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, 0);
      gap = $urandom_range(0, 3);
      for (int k = 0; k < gap; k++) begin
        tick();
        check_idle("gap", held_quo, iter_limit(ro));
      end
    end

    check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
